wfg_wb_sample_fetch: RTL and testbench
======================================

Name: wfg_wb_sample_fetch

Overview:
- Wishbone master that cyclically reads 32-bit sample words from the sample memory slave (SRAM bridge, 2x512 words) over a programmable word-address window.
- Fetched words go into a small FIFO and leave on a valid/ready sample stream toward the waveform drive stage.
- Sits directly upstream of the memory slave: it drives the slave's Wishbone inputs and consumes its read data and ack.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2.

Ports:
- io_wbs_clk  input  1  system clock, all logic on rising edge.
- io_wbs_rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run control, level-sensitive.
- start_addr  input  32  byte address of first sample; bits [1:0] ignored.
- end_addr  input  32  byte address of last sample, inclusive; bits [1:0] ignored.
- m_wbs_adr  output  32  Wishbone address, bits [1:0] always 0.
- m_wbs_datwr  output  32  Wishbone write data, constant 0.
- m_wbs_datrd  input  32  Wishbone read data.
- m_wbs_we  output  1  constant 0; block only reads.
- m_wbs_stb  output  1  Wishbone strobe.
- m_wbs_cyc  output  1  Wishbone cycle, identical to m_wbs_stb.
- m_wbs_ack  input  1  Wishbone acknowledge.
- sample_data  output  32  FIFO head word.
- sample_valid  output  1  FIFO not empty.
- sample_ready  input  1  consumer accepts the head word.
- busy  output  1  FSM not in IDLE.
- wrap  output  1  one-cycle pulse when the end_addr word is acked.

Behaviour:
- Reset (async, io_wbs_rst_n low): FSM=IDLE; FIFO emptied; cur_addr=0. All outputs 0: adr, stb, cyc, we, datwr, sample_data, sample_valid, busy, wrap.
- Start: the 0->1 transition of enable is detected by a registered copy of enable. On that edge: FIFO flushed, cur_addr={start_addr[31:2],2'b00}, FSM -> REQ next cycle.
- FSM states: IDLE, REQ, GAP, HOLD.
- REQ: stb=cyc=1, adr=cur_addr. Held until ack=1.
  - Ack cycle: push datrd into FIFO.
  - If cur_addr[31:2] >= end_addr[31:2]: cur_addr=start word and wrap pulses for that cycle. Otherwise cur_addr += 4.
  - Next state GAP.
- GAP: stb=cyc=0 for exactly one cycle, as the slave requires to avoid a double ack.
  - enable=0 -> IDLE.
  - Else if FIFO count < FIFO_DEPTH -> REQ.
  - Else -> HOLD.
- HOLD: stb=0. enable=0 -> IDLE. Else count < FIFO_DEPTH -> REQ.
- Only one transaction outstanding at a time. REQ is entered only when a FIFO slot is free, so a push never overflows.
- Against the one-cycle-ack slave the request occupies 2 cycles plus 1 GAP, so the minimum period is 3 cycles per sample.
- enable dropping during REQ: the transaction completes and its data is pushed, then GAP -> IDLE. stb is never withdrawn before ack.
- Stream side:
  - sample_valid = count != 0; sample_data = FIFO head.
  - Pop on sample_valid && sample_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty is ignored.
  - The FIFO keeps draining after enable=0 and is cleared only by the next enable rising edge or by reset.
- Window rules:
  - start == end: the same word is fetched repeatedly, with wrap on every ack.
  - start > end: same behaviour as start == end (the >= test).
  - cur_addr arithmetic is 32-bit and wraps modulo 2^32.
- start_addr and end_addr are sampled continuously; software changes them only while enable=0.
- busy = (state != IDLE).

Test Plan:
- Reset mid-REQ (stb=1, FIFO holding 2 words) -> stb, cyc, sample_valid and busy drop to 0 immediately (asynchronous); after release the FSM is IDLE and the FIFO is empty.
- Memory preloaded with words k at 0x000..0x00C; start=0x000, end=0x00C, sample_ready=1 -> stream is 0,1,2,3,0,1,…; wrap pulses on each ack of 0x00C; adr never exceeds 0x00C; stb low exactly one cycle between requests.
- sample_ready=0, FIFO_DEPTH=4, window of 8 words -> exactly 4 transactions, then FSM in HOLD with stb=0. Raise ready for 1 cycle -> one pop, then exactly one new request.
- start=end=0x804 (memory 1, word 1, value 0xA5A5_0001) -> every sample equals 0xA5A5_0001; wrap is high on every ack.
- enable dropped in the cycle after stb rises -> stb held until ack, the word is pushed, then IDLE. The FIFO still drains; re-enable flushes it and the first adr equals start_addr.
- Words 0xFFFF_FFF0 and 0xFFFF_FFFC in the window -> after 0xFFFF_FFFC the address wraps to start; there is no X and no out-of-window access.

Source files
------------

// File: rtl/wfg_wb_sample_fetch.sv
// Wishbone read master that cyclically fetches 32-bit sample words over a
// programmable word window and streams them out through a small FIFO.
module wfg_wb_sample_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst_n,
  input  logic        enable,
  input  logic [31:0] start_addr,
  input  logic [31:0] end_addr,
  output logic [31:0] m_wbs_adr,
  output logic [31:0] m_wbs_datwr,
  input  logic [31:0] m_wbs_datrd,
  output logic        m_wbs_we,
  output logic        m_wbs_stb,
  output logic        m_wbs_cyc,
  input  logic        m_wbs_ack,
  output logic [31:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        wrap
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            stb_r;
  logic            busy_r;
  logic            enable_r;
  logic            pend_r;
  logic [31:0]     cur_addr_r;
  logic [31:0]     fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            rise_s;
  logic            ack_s;
  logic            last_s;
  logic            restart_ack_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic            room_s;
  logic [31:0]     start_word_s;
  logic            unused_addr_bits_s;

  assign unused_addr_bits_s = ^{start_addr[1:0], end_addr[1:0]};

  assign rise_s        = enable & ~enable_r;
  assign ack_s         = (state_r == REQ) & m_wbs_ack;
  assign last_s        = (cur_addr_r[31:2] >= end_addr[31:2]);
  assign start_word_s  = {start_addr[31:2], 2'b00};
  // A restart requested while a read is outstanding is applied on its ack,
  // so the strobe is never withdrawn early and the stale word is discarded.
  assign restart_ack_s = ack_s & (pend_r | rise_s);
  assign push_s        = ack_s & ~restart_ack_s;
  assign flush_s       = (rise_s & (state_r != REQ)) | restart_ack_s;
  assign pop_s         = (count_r != {CW{1'b0}}) & sample_ready & ~flush_s;
  assign room_s        = (count_r < CW'(FIFO_DEPTH));

  // Next-state decode for the request sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) state_nxt_s = REQ;
        else        state_nxt_s = IDLE;
      end
      REQ: begin
        if (m_wbs_ack) state_nxt_s = GAP;
        else           state_nxt_s = REQ;
      end
      GAP, HOLD: begin
        if (rise_s)       state_nxt_s = REQ;
        else if (!enable) state_nxt_s = IDLE;
        else if (room_s)  state_nxt_s = REQ;
        else              state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state with strobe and busy registered from the next state.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_r <= IDLE;
      stb_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      stb_r   <= (state_nxt_s == REQ);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Enable edge detector and pending-restart flag.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      enable_r <= 1'b0;
      pend_r   <= 1'b0;
    end else begin
      enable_r <= enable;
      if (ack_s)
        pend_r <= 1'b0;
      else if ((state_r == REQ) && rise_s)
        pend_r <= 1'b1;
      else
        pend_r <= pend_r;
    end
  end

  // Fetch address walks the window and returns to start after the end word.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      cur_addr_r <= 32'd0;
    end else if (flush_s) begin
      cur_addr_r <= start_word_s;
    end else if (ack_s) begin
      if (last_s) cur_addr_r <= start_word_s;
      else        cur_addr_r <= cur_addr_r + 32'd4;
    end else begin
      cur_addr_r <= cur_addr_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 32'd0;
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= m_wbs_datrd;
    end
  end

  assign m_wbs_adr    = cur_addr_r;
  assign m_wbs_datwr  = 32'd0;
  assign m_wbs_we     = 1'b0;
  assign m_wbs_stb    = stb_r;
  assign m_wbs_cyc    = stb_r;
  assign busy         = busy_r;
  assign sample_valid = (count_r != {CW{1'b0}});
  assign sample_data  = sample_valid ? fifo_mem_r[rd_ptr_r] : 32'd0;
  // Wrap must coincide with the ack of the end word, so it decodes the input ack.
  assign wrap         = ack_s & last_s;

endmodule

// File: tb/tb_wfg_wb_sample_fetch.sv
// Bench for wfg_wb_sample_fetch: one-cycle-ack memory slave, window/stream
// reference model and per-scenario directed checks.
module tb_wfg_wb_sample_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic [31:0] end_addr = 32'd0;
  logic [31:0] adr, datwr, datrd, sample_data;
  logic        we, stb, cyc, ack, sample_valid, busy, wrap;
  logic        sample_ready = 1'b0;

  wfg_wb_sample_fetch #(.FIFO_DEPTH(4)) dut (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n), .enable(enable),
    .start_addr(start_addr), .end_addr(end_addr),
    .m_wbs_adr(adr), .m_wbs_datwr(datwr), .m_wbs_datrd(datrd),
    .m_wbs_we(we), .m_wbs_stb(stb), .m_wbs_cyc(cyc), .m_wbs_ack(ack),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h3C3C_0000;
  endfunction

  // Memory slave: acks one cycle after strobe, never twice in a row.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      datrd <= 32'd0;
    end else begin
      ack   <= stb && !ack;
      datrd <= mem_val(adr);
    end
  end

  int checks = 0, errors = 0;
  logic [31:0] win_q[$];
  logic [31:0] exp_q[$];
  int win_idx = 0;
  bit mon_en = 1'b0, gap_chk = 1'b0, seen_req = 1'b0, prev_stb = 1'b0;
  int ack_cnt = 0, wrap_cnt = 0, pop_cnt = 0, low_run = 0;
  logic [31:0] mon_exp;
  bit exp_wrap;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Window as an explicit list of word addresses, cycled in order.
  task automatic build_window(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] a;
    logic [31:0] sw;
    logic [31:0] ew;
    sw = {s[31:2], 2'b00};
    ew = {e[31:2], 2'b00};
    win_q.delete();
    win_idx = 0;
    if (sw >= ew) win_q.push_back(sw);
    else begin
      a = sw;
      while (1) begin
        win_q.push_back(a);
        if (a == ew) break;
        a = a + 32'd4;
      end
    end
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] e);
    start_addr = s;
    end_addr = e;
    build_window(s, e);
    seen_req = 1'b0;
    low_run = 0;
    enable = 1'b1;
    tick(1);
    exp_q.delete();
  endtask

  task automatic stop_run();
    int n;
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin tick(1); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle busy=%b want 0", busy); end
    sample_ready = 1'b1;
    n = 0;
    while (sample_valid !== 1'b0 && n < 30) begin tick(1); n++; end
    sample_ready = 1'b0;
    tick(1);
    checks++;
    if (exp_q.size() != 0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain model_left=%0d valid=%b want 0/0", exp_q.size(), sample_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({adr, datwr, sample_data, stb, cyc, we, sample_valid, busy, wrap} !== 101'd0) begin
      errors++;
      $display("FAIL reset_outputs adr=%h stb=%b valid=%b busy=%b wrap=%b want all 0", adr, stb, sample_valid, busy, wrap);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if ({stb, sample_valid, busy, wrap} !== 4'd0) begin
      errors++;
      $display("FAIL after_reset stb=%b valid=%b busy=%b wrap=%b want 0", stb, sample_valid, busy, wrap);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_cyclic();
    int a0, w0, p0;
    for (int k = 0; k < 4; k++) mem[32'(k * 4)] = 32'(k);
    sample_ready = 1'b1;
    gap_chk = 1'b1;
    a0 = ack_cnt; w0 = wrap_cnt; p0 = pop_cnt;
    start_run(32'h0000_0000, 32'h0000_000C);
    tick(60);
    checks++;
    if (ack_cnt - a0 != 20) begin errors++; $display("FAIL cyclic_rate acks=%0d want 20", ack_cnt - a0); end
    checks++;
    if (wrap_cnt - w0 != 5) begin errors++; $display("FAIL cyclic_wraps got=%0d want 5", wrap_cnt - w0); end
    checks++;
    if (pop_cnt - p0 < 18) begin errors++; $display("FAIL cyclic_pops got=%0d want >=18", pop_cnt - p0); end
    gap_chk = 1'b0;
    stop_run();
  endtask

  task automatic test_hold();
    int a0;
    sample_ready = 1'b0;
    a0 = ack_cnt;
    start_run(32'h0000_0100, 32'h0000_011C);
    tick(40);
    checks++;
    if (ack_cnt - a0 != 4) begin errors++; $display("FAIL hold_fill acks=%0d want 4", ack_cnt - a0); end
    checks++;
    if (stb !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_state stb=%b busy=%b want 0/1", stb, busy); end
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    tick(20);
    checks++;
    if (ack_cnt - a0 != 5) begin errors++; $display("FAIL hold_refill acks=%0d want 5", ack_cnt - a0); end
    checks++;
    if (stb !== 1'b0) begin errors++; $display("FAIL hold_stb got=%b want 0", stb); end
    stop_run();
  endtask

  task automatic test_single();
    int a0, w0;
    mem[32'h0000_0804] = 32'hA5A5_0001;
    a0 = ack_cnt; w0 = wrap_cnt;
    start_run(32'h0000_0804, 32'h0000_0807);
    for (int i = 0; i < 60; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      tick(1);
      if (sample_valid && sample_ready) begin
        checks++;
        if (sample_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got=%h want a5a50001", sample_data); end
      end
    end
    checks++;
    if (ack_cnt == a0 || wrap_cnt - w0 != ack_cnt - a0) begin
      errors++; $display("FAIL single_wrap wraps=%0d acks=%0d want equal nonzero", wrap_cnt - w0, ack_cnt - a0);
    end
    stop_run();
    a0 = ack_cnt; w0 = wrap_cnt;
    start_run(32'h0000_0820, 32'h0000_0810);
    for (int i = 0; i < 40; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    checks++;
    if (ack_cnt == a0 || wrap_cnt - w0 != ack_cnt - a0) begin
      errors++; $display("FAIL inverted_wrap wraps=%0d acks=%0d want equal nonzero", wrap_cnt - w0, ack_cnt - a0);
    end
    stop_run();
  endtask

  task automatic test_drop();
    int a0, n;
    sample_ready = 1'b0;
    a0 = ack_cnt;
    start_run(32'h0000_0040, 32'h0000_005C);
    n = 0;
    while (!(ack_cnt - a0 == 2 && stb === 1'b1) && n < 40) begin tick(1); n++; end
    checks++;
    if (stb !== 1'b1) begin errors++; $display("FAIL drop_wait stb=%b want 1", stb); end
    enable = 1'b0;
    n = 0;
    while (stb === 1'b1 && n < 10) begin tick(1); n++; end
    checks++;
    if (ack_cnt - a0 != 3) begin errors++; $display("FAIL drop_complete acks=%0d want 3", ack_cnt - a0); end
    tick(3);
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b1) begin
      errors++; $display("FAIL drop_idle busy=%b valid=%b want 0/1", busy, sample_valid);
    end
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    start_run(32'h0000_0040, 32'h0000_005C);
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL reenable_flush valid=%b want 0", sample_valid); end
    n = 0;
    while (stb !== 1'b1 && n < 5) begin tick(1); n++; end
    checks++;
    if (stb !== 1'b1 || adr !== 32'h0000_0040) begin
      errors++; $display("FAIL reenable_adr stb=%b adr=%h want 1/00000040", stb, adr);
    end
    stop_run();
  endtask

  task automatic test_addr_wrap();
    int a0;
    a0 = ack_cnt;
    start_run(32'hFFFF_FFF0, 32'hFFFF_FFFC);
    for (int i = 0; i < 80; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      tick(1);
      checks++;
      if ((^adr) === 1'bx || (^sample_data) === 1'bx) begin
        errors++; $display("FAIL top_no_x adr=%h data=%h want known", adr, sample_data);
      end
    end
    checks++;
    if (ack_cnt - a0 < 8) begin errors++; $display("FAIL top_progress acks=%0d want >=8", ack_cnt - a0); end
    stop_run();
  endtask

  task automatic test_random();
    logic [31:0] s, e;
    for (int it = 0; it < 4; it++) begin
      s = 32'($urandom_range(4, 255)) * 32'd4;
      if ($urandom_range(0, 3) == 0) e = s - 32'd8;
      else e = s + 32'($urandom_range(0, 5)) * 32'd4 + 32'($urandom_range(0, 3));
      start_run(s, e);
      for (int i = 0; i < 50; i++) begin
        sample_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
      stop_run();
    end
  endtask

  task automatic test_reset_midreq();
    int a0, n;
    sample_ready = 1'b0;
    a0 = ack_cnt;
    start_run(32'h0000_0000, 32'h0000_001C);
    n = 0;
    while (!(ack_cnt - a0 == 2 && stb === 1'b1) && n < 40) begin tick(1); n++; end
    checks++;
    if (stb !== 1'b1 || sample_valid !== 1'b1) begin
      errors++; $display("FAIL midreq_setup stb=%b valid=%b want 1/1", stb, sample_valid);
    end
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({stb, cyc, sample_valid, busy} !== 4'd0) begin
      errors++; $display("FAIL async_reset stb=%b cyc=%b valid=%b busy=%b want 0", stb, cyc, sample_valid, busy);
    end
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if ({stb, sample_valid, busy} !== 3'd0) begin
      errors++; $display("FAIL post_reset stb=%b valid=%b busy=%b want 0", stb, sample_valid, busy);
    end
  endtask

  initial begin
    // Background scoreboard: address order, wrap, stream contents, gap timing.
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          checks++;
          if (sample_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL valid got=%b want %b", sample_valid, exp_q.size() != 0);
          end
          if (stb) begin
            checks++;
            if (adr !== win_q[win_idx] || cyc !== 1'b1) begin
              errors++; $display("FAIL req_adr got=%h cyc=%b want %h/1", adr, cyc, win_q[win_idx]);
            end
          end
          if (stb && ack) begin
            exp_wrap = (win_idx == win_q.size() - 1);
            checks++;
            if (wrap !== exp_wrap) begin errors++; $display("FAIL wrap got=%b want %b at %h", wrap, exp_wrap, adr); end
            exp_q.push_back(mem_val(win_q[win_idx]));
            win_idx = exp_wrap ? 0 : win_idx + 1;
            ack_cnt++;
            if (wrap === 1'b1) wrap_cnt++;
          end else begin
            checks++;
            if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%b want 0", wrap); end
          end
          if (sample_valid && sample_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL pop_empty data=%h want no sample", sample_data);
            end else begin
              mon_exp = exp_q.pop_front();
              if (sample_data !== mon_exp) begin errors++; $display("FAIL sample got=%h want %h", sample_data, mon_exp); end
            end
            pop_cnt++;
          end
          if (gap_chk) begin
            if (stb && !prev_stb && seen_req) begin
              checks++;
              if (low_run != 1) begin errors++; $display("FAIL gap_len got=%0d want 1", low_run); end
            end
            if (stb) begin low_run = 0; seen_req = 1'b1; end
            else low_run++;
          end
        end
        prev_stb = stb;
      end
    join_none

    test_reset();
    test_cyclic();
    test_hold();
    test_single();
    test_drop();
    test_addr_wrap();
    test_random();
    test_reset_midreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
